wb_int_ctrl: RTL



---
 rtl/wb_int_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_int_ctrl.sv
// rtl/wb_int_ctrl.sv - parametrised interrupt controller on the register Wishbone
`ifndef MM_REG_ADDR_BITS
`define MM_REG_ADDR_BITS 8
`endif

module wb_int_ctrl #(
  parameter int NUM_SRC      = 16,
  parameter int ADDR_BITS    = `MM_REG_ADDR_BITS,
  parameter int ADDR_PENDING = 0,
  parameter int ADDR_ENABLE  = 1,
  parameter int ADDR_MODE    = 2,
  parameter int ADDR_CLAIM   = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_reset,
  input  logic [NUM_SRC-1:0]   src_in,
  input  logic                 WB_RD_STB_I,
  input  logic [ADDR_BITS-1:0] WB_RD_ADR_I,
  output logic [31:0]          WB_RD_DAT_O,
  output logic                 WB_RD_ACK_O,
  input  logic                 WB_WR_STB_I,
  input  logic                 WB_WR_WE_I,
  input  logic [3:0]           WB_WR_SEL_I,
  input  logic [ADDR_BITS-1:0] WB_WR_ADR_I,
  input  logic [31:0]          WB_WR_DAT_I,
  output logic                 WB_WR_ACK_O,
  output logic                 int_gen
);

  localparam logic [5:0] NUM_SRC_W = 6'(NUM_SRC);

  logic [NUM_SRC-1:0] src_meta;
  logic [NUM_SRC-1:0] src_stable;
  logic [NUM_SRC-1:0] src_prev;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] mode;
  logic [4:0]         rr_ptr;
  logic [4:0]         sel_id;
  logic               sel_valid;

  // Write decode
  logic wr_en;
  logic wr_pending;
  logic wr_enable;
  logic wr_mode;
  logic wr_claim;

  assign wr_en      = WB_WR_STB_I & WB_WR_WE_I;
  assign wr_pending = wr_en && (WB_WR_ADR_I == ADDR_BITS'(ADDR_PENDING));
  assign wr_enable  = wr_en && (WB_WR_ADR_I == ADDR_BITS'(ADDR_ENABLE));
  assign wr_mode    = wr_en && (WB_WR_ADR_I == ADDR_BITS'(ADDR_MODE));
  assign wr_claim   = wr_en && (WB_WR_ADR_I == ADDR_BITS'(ADDR_CLAIM));

  // Byte-lane merge for ENABLE / MODE; bits at or above NUM_SRC simply do not exist
  logic [31:0]        lane_mask;
  logic [NUM_SRC-1:0] wr_mask;
  logic [NUM_SRC-1:0] wr_data;
  logic [NUM_SRC-1:0] enable_new;
  logic [NUM_SRC-1:0] mode_new;
  logic [NUM_SRC-1:0] mode_flip;

  assign lane_mask  = {{8{WB_WR_SEL_I[3]}}, {8{WB_WR_SEL_I[2]}},
                       {8{WB_WR_SEL_I[1]}}, {8{WB_WR_SEL_I[0]}}};
  assign wr_mask    = lane_mask[NUM_SRC-1:0];
  assign wr_data    = WB_WR_DAT_I[NUM_SRC-1:0];
  assign enable_new = (enable & ~wr_mask) | (wr_data & wr_mask);
  assign mode_new   = (mode & ~wr_mask) | (wr_data & wr_mask);
  assign mode_flip  = wr_mode ? (mode ^ mode_new) : '0;

  // Claim decode; out-of-range ids are ignored entirely
  logic [4:0]         claim_id;
  logic               claim_ok;
  logic [31:0]        claim_onehot;
  logic [NUM_SRC-1:0] claim_clr;
  logic [5:0]         claim_inc;
  logic [4:0]         rr_next;

  assign claim_id     = WB_WR_DAT_I[4:0];
  assign claim_ok     = wr_claim && ({1'b0, claim_id} < NUM_SRC_W);
  assign claim_onehot = 32'd1 << claim_id;
  assign claim_clr    = claim_ok ? claim_onehot[NUM_SRC-1:0] : '0;
  assign claim_inc    = {1'b0, claim_id} + 6'd1;
  assign rr_next      = claim_ok ? ((claim_inc == NUM_SRC_W) ? 5'd0 : claim_inc[4:0]) : rr_ptr;

  // Pending update: edge sources latch rises (set beats clear), level sources follow
  // the synchronised input, and a mode change on a bit wipes that bit
  logic [NUM_SRC-1:0] w1c_clr;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] edge_next;
  logic [NUM_SRC-1:0] pending_next;

  assign w1c_clr      = wr_pending ? wr_data : '0;
  assign rise         = src_stable & ~src_prev;
  assign edge_next    = rise | (pending & ~(w1c_clr | claim_clr));
  assign pending_next = ((mode & edge_next) | (~mode & src_stable)) & ~mode_flip;

  // Round-robin search from rr_ptr upward, wrapping at NUM_SRC
  logic [NUM_SRC-1:0] active;
  logic [31:0]        active32;
  logic [5:0]         idx;
  logic               found;
  logic [4:0]         found_id;

  assign active   = pending & enable;
  assign active32 = 32'(active);

  // First active source at or after rr_ptr
  always_comb begin
    found    = 1'b0;
    found_id = 5'd0;
    idx      = 6'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = {1'b0, rr_ptr} + 6'(i);
      if (idx >= NUM_SRC_W) idx = idx - NUM_SRC_W;
      if (!found && active32[idx[4:0]]) begin
        found    = 1'b1;
        found_id = idx[4:0];
      end
    end
  end

  // Read data mux; unmapped addresses return 0
  logic [31:0] rd_mux;

  // Select the register addressed by the read port
  always_comb begin
    rd_mux = 32'd0;
    if (WB_RD_ADR_I == ADDR_BITS'(ADDR_PENDING))     rd_mux = 32'(pending);
    else if (WB_RD_ADR_I == ADDR_BITS'(ADDR_ENABLE)) rd_mux = 32'(enable);
    else if (WB_RD_ADR_I == ADDR_BITS'(ADDR_MODE))   rd_mux = 32'(mode);
    else if (WB_RD_ADR_I == ADDR_BITS'(ADDR_CLAIM))  rd_mux = {sel_valid, 26'd0, sel_id};
  end

  // Two-flop synchroniser plus one-cycle history for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_meta   <= '0;
      src_stable <= '0;
      src_prev   <= '0;
    end else if (sync_reset) begin
      src_meta   <= '0;
      src_stable <= '0;
      src_prev   <= '0;
    end else begin
      src_meta   <= src_in;
      src_stable <= src_meta;
      src_prev   <= src_stable;
    end
  end

  // Control/status registers and the round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
      rr_ptr  <= 5'd0;
    end else if (sync_reset) begin
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
      rr_ptr  <= 5'd0;
    end else begin
      pending <= pending_next;
      if (wr_enable) enable <= enable_new;
      if (wr_mode)   mode   <= mode_new;
      rr_ptr <= rr_next;
    end
  end

  // Registered arbitration result and interrupt line; sel_id holds when nothing is active
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_valid <= 1'b0;
      sel_id    <= 5'd0;
      int_gen   <= 1'b0;
    end else if (sync_reset) begin
      sel_valid <= 1'b0;
      sel_id    <= 5'd0;
      int_gen   <= 1'b0;
    end else begin
      sel_valid <= found;
      if (found) sel_id <= found_id;
      int_gen <= |active;
    end
  end

  // Bus acknowledges and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      WB_RD_DAT_O <= 32'd0;
      WB_RD_ACK_O <= 1'b0;
      WB_WR_ACK_O <= 1'b0;
    end else if (sync_reset) begin
      WB_RD_DAT_O <= 32'd0;
      WB_RD_ACK_O <= 1'b0;
      WB_WR_ACK_O <= 1'b0;
    end else begin
      WB_RD_DAT_O <= WB_RD_STB_I ? rd_mux : 32'd0;
      WB_RD_ACK_O <= WB_RD_STB_I;
      WB_WR_ACK_O <= wr_en;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{WB_WR_DAT_I[31:NUM_SRC], lane_mask[31:NUM_SRC], claim_onehot[31:NUM_SRC]};

endmodule
